// File: rtl/conv_seq_ctrl_if.sv
// Sensor-side strobes and sequencer outputs for the convolution path.
// The sequencer takes the slave side; the producer/observer takes the master side.
interface conv_seq_ctrl_if #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   logic          iFVAL;
   logic          iDVAL;
   logic          iMODE_TOG;
   logic          oVERTICAL;
   logic [XW-1:0] oX;
   logic [YW-1:0] oY;
   logic          oDVAL;
   logic          oFRAME_DONE;
   logic          oERR;

   modport master (
      output iFVAL, iDVAL, iMODE_TOG,
      input  oVERTICAL, oX, oY, oDVAL, oFRAME_DONE, oERR
   );

   modport slave (
      input  iFVAL, iDVAL, iMODE_TOG,
      output oVERTICAL, oX, oY, oDVAL, oFRAME_DONE, oERR
   );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Frame/line sequencer: tracks pixel position, latches the kernel direction at
// frame start and emits a latency-matched valid for fully populated 3x3 windows.
module conv_seq_ctrl #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int LAT   = 3
) (
   input  logic           iCLK,
   input  logic           iRST,
   conv_seq_ctrl_if.slave bus
);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
   localparam logic [XW-1:0] X_MIN  = XW'(2);
   localparam logic [YW-1:0] Y_MIN  = YW'(2);

   typedef enum logic [1:0] {IDLE = 2'd0, FRAME = 2'd1, DONE = 2'd2} state_t;

   state_t        state_q;
   logic          fval_q;
   logic          arm_q;
   logic          pend_q;
   logic          vert_q;
   logic          done_q;
   logic          err_q;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [LAT-1:0] dly_q;

   logic fval_rise;
   logic win_d;
   logic last_px;

   // arm_q blocks a frame start until iFVAL has been seen low after reset,
   // so a frame already in flight at reset release is skipped.
   always_comb begin
      fval_rise = bus.iFVAL & ~fval_q & arm_q;
      win_d     = (state_q == FRAME) & bus.iDVAL & (x_q >= X_MIN) & (y_q >= Y_MIN);
      last_px   = (x_q == X_LAST) & (y_q == Y_LAST);
      x_d       = x_q + 1'b1;
      y_d       = y_q;
      if (x_q == X_LAST) begin
         x_d = '0;
         y_d = last_px ? '0 : y_q + 1'b1;
      end
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q <= IDLE;
         fval_q  <= 1'b0;
         arm_q   <= 1'b0;
         pend_q  <= 1'b0;
         vert_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         dly_q   <= '0;
      end else begin
         fval_q <= bus.iFVAL;
         if (!bus.iFVAL) arm_q <= 1'b1;
         dly_q[0] <= win_d;
         for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
         done_q <= 1'b0;
         if (bus.iMODE_TOG) pend_q <= 1'b1;

         case (state_q)
            IDLE: begin
               if (bus.iDVAL) err_q <= 1'b1;
               if (fval_rise) begin
                  state_q <= FRAME;
                  x_q     <= '0;
                  y_q     <= '0;
                  vert_q  <= vert_q ^ pend_q;
                  // A request in this same cycle is kept for the next frame.
                  pend_q  <= bus.iMODE_TOG;
               end
            end
            FRAME: begin
               if (!bus.iFVAL) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else if (bus.iDVAL) begin
                  x_q <= x_d;
                  y_q <= y_d;
                  if (last_px) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               if (bus.iDVAL) err_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.oVERTICAL   = vert_q;
   assign bus.oX          = x_q;
   assign bus.oY          = y_q;
   assign bus.oDVAL       = dly_q[LAT-1];
   assign bus.oFRAME_DONE = done_q;
   assign bus.oERR        = err_q;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: directed frames plus random frames against a
// pixel-count reference model.
module tb_conv_seq_ctrl;
   localparam int W   = 4;
   localparam int H   = 3;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv_seq_ctrl_if #(.IMG_W(W), .IMG_H(H)) bus();
   conv_seq_ctrl #(.IMG_W(W), .IMG_H(H), .LAT(LAT)) dut (
      .iCLK (clk),
      .iRST (rst_n),
      .bus  (bus)
   );

   int checks = 0;
   int failures = 0;
   int dval_cnt = 0;
   int done_cnt = 0;

   // Reference model: frame membership, pixel count within frame, and the
   // window-valid history as a queue of bits.
   bit m_in, m_done, m_pend, m_vert, m_err, m_prevf, m_arm, e_dval;
   int m_n;
   bit m_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".x"},    bus.oX,          m_n % W);
      chk({tag, ".y"},    bus.oY,          m_n / W);
      chk({tag, ".vert"}, bus.oVERTICAL,   m_vert);
      chk({tag, ".dval"}, bus.oDVAL,       e_dval);
      chk({tag, ".done"}, bus.oFRAME_DONE, m_done);
      chk({tag, ".err"},  bus.oERR,        m_err);
   endtask

   task automatic model_reset();
      m_in = 0; m_done = 0; m_pend = 0; m_vert = 0; m_err = 0;
      m_prevf = 0; m_arm = 0; m_n = 0; e_dval = 0;
      m_q = {};
      repeat (LAT - 1) m_q.push_back(1'b0);
   endtask

   task automatic cyc(input string tag, input bit f, input bit d, input bit t);
      bit win, nd;
      bus.iFVAL = f; bus.iDVAL = d; bus.iMODE_TOG = t;
      win = m_in && d && (m_n % W >= 2) && (m_n / W >= 2);
      nd  = 0;
      if (m_in) begin
         if (!f) begin
            m_err = 1; m_in = 0;
         end else if (d) begin
            m_n++;
            if (m_n == W * H) begin m_n = 0; m_in = 0; nd = 1; end
         end
      end else if (m_done) begin
         if (d) m_err = 1;
      end else begin
         if (d) m_err = 1;
         if (f && !m_prevf && m_arm) begin
            m_in = 1; m_n = 0; m_vert ^= m_pend; m_pend = 0;
         end
      end
      m_done = nd;
      if (t) m_pend = 1;
      if (!f) m_arm = 1;
      m_prevf = f;
      m_q.push_back(win);
      e_dval = m_q.pop_front();
      @(posedge clk); #1;
      if (bus.oDVAL === 1'b1) dval_cnt++;
      if (bus.oFRAME_DONE === 1'b1) done_cnt++;
      check_all(tag);
   endtask

   task automatic frame(input string tag, input int npix, input bit gapped,
                        input int tog_a, input int tog_b);
      int sent;
      bit d;
      sent = 0; dval_cnt = 0; done_cnt = 0;
      cyc(tag, 1, 0, 0);
      for (int k = 0; k < 100 && sent < npix; k++) begin
         d = gapped ? (k % 2 == 0) : 1'b1;
         cyc(tag, 1, d, (k == tog_a) || (k == tog_b));
         if (d) sent++;
      end
      if (npix < W * H) cyc(tag, 0, 0, 0);
      else begin cyc(tag, 1, 0, 0); cyc(tag, 0, 0, 0); end
      cyc(tag, 0, 0, 0);
   endtask

   initial begin
      bit vprev, shortf, d, f, t;
      int cut, sent;
      bus.iFVAL = 0; bus.iDVAL = 0; bus.iMODE_TOG = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;
      cyc("idle", 0, 0, 0);
      cyc("idle", 0, 0, 0);

      frame("full", W * H, 0, -1, -1);
      chk("full.dval_count", dval_cnt, (W - 2) * (H - 2));
      chk("full.done_count", done_cnt, 1);

      frame("gap", W * H, 1, -1, -1);
      chk("gap.dval_count", dval_cnt, (W - 2) * (H - 2));
      chk("gap.done_count", done_cnt, 1);

      frame("tog1", W * H, 0, 5, -1);
      chk("tog1.vert_hold", bus.oVERTICAL, 0);
      frame("tog1b", W * H, 0, -1, -1);
      chk("tog1b.vert_new", bus.oVERTICAL, 1);
      vprev = bus.oVERTICAL;
      frame("tog2", W * H, 0, 3, 6);
      frame("tog2b", W * H, 0, -1, -1);
      chk("tog2b.vert_once", bus.oVERTICAL, !vprev);

      frame("short", 7, 0, -1, -1);
      chk("short.err", bus.oERR, 1);
      chk("short.done_count", done_cnt, 0);
      frame("after", W * H, 0, -1, -1);
      chk("after.done_count", done_cnt, 1);
      chk("after.err_sticky", bus.oERR, 1);

      // Asynchronous reset in the middle of a frame, released with iFVAL high.
      cyc("mid", 1, 0, 0);
      cyc("mid", 1, 1, 0);
      cyc("mid", 1, 1, 0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(posedge clk); #1;
      check_all("in_rst");
      rst_n = 1'b1;
      repeat (3) cyc("rel_fval_hi", 1, 0, 0);
      cyc("rel_low", 0, 0, 0);

      cyc("stray", 0, 1, 0);
      chk("stray.err", bus.oERR, 1);
      cyc("stray", 0, 0, 0);
      frame("post_stray", W * H, 0, -1, -1);
      chk("post_stray.dval_count", dval_cnt, (W - 2) * (H - 2));

      for (int r = 0; r < 20; r++) begin
         repeat ($urandom_range(1, 3)) cyc("rnd_gap", 0, ($urandom % 16) == 0, 0);
         shortf = ($urandom % 4) == 0;
         cut    = $urandom_range(1, W * H - 1);
         sent   = 0;
         cyc("rnd_rise", 1, 0, ($urandom % 8) == 0);
         for (int k = 0; k < 60 && m_in; k++) begin
            d = $urandom % 2;
            f = !(shortf && sent >= cut);
            t = ($urandom % 8) == 0;
            cyc("rnd", f, d, t);
            if (f && d) sent++;
         end
      end
      cyc("rnd_tail", 0, 0, 0);
      cyc("rnd_tail", 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
